// File: rtl/timer_pkg.sv
// Shared types and helpers for the multi-channel countdown timer bank.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package timer_pkg;

  // Per-channel lifecycle.
  typedef enum logic [1:0] {
    CH_IDLE  = 2'd0,
    CH_RUN   = 2'd1,
    CH_PAUSE = 2'd2,
    CH_RING  = 2'd3
  } ch_state_t;

  // Minutes and seconds are both carried in 6-bit fields.
  localparam int FIELD_W = 6;
  localparam logic [FIELD_W-1:0] SEC_MAX = 6'd59;

  // Width of an index able to address n items (never below one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One MM:SS countdown channel: preset entry, run/pause, buzzer and auto-repeat.
// Latency: every strobe or tick acts at the edge it is sampled; outputs are flops.
// Backpressure: none; strobes are one-cycle commands and are never stalled.
//
// Ports:
//   clk, reset            clock, async active-low reset
//   sec_tick              one-cycle seconds strobe from the shared prescaler
//   clr/start/pause       command strobes, already edge-detected and channel-qualified
//   add_min/add_sec       preset/value increment strobes
//   repeat_en             auto-repeat request, captured when a start is accepted
//   min_left/sec_left     current remaining value
//   running/buzzer        channel in RUN / in RING
module timer_channel
  import timer_pkg::*;
#(
  parameter int MAX_MIN   = 59,
  parameter int BUZZ_SECS = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sec_tick,
  input  logic               clr,
  input  logic               start,
  input  logic               pause,
  input  logic               add_min,
  input  logic               add_sec,
  input  logic               repeat_en,
  output logic [FIELD_W-1:0] min_left,
  output logic [FIELD_W-1:0] sec_left,
  output logic               running,
  output logic               buzzer
);

  localparam int BCNT_W = $clog2(BUZZ_SECS + 1);
  localparam logic [FIELD_W-1:0] MIN_TOP  = FIELD_W'(MAX_MIN);
  localparam logic [BCNT_W-1:0]  BCNT_END = BCNT_W'(BUZZ_SECS - 1);

  ch_state_t          state_q, state_d;
  logic [FIELD_W-1:0] min_q, min_d;
  logic [FIELD_W-1:0] sec_q, sec_d;
  logic [FIELD_W-1:0] pmin_q, pmin_d;
  logic [FIELD_W-1:0] psec_q, psec_d;
  logic               rep_q, rep_d;
  logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
  logic               running_q, buzzer_q;

  logic               is_zero;
  logic               last_sec;
  logic [FIELD_W-1:0] inc_min;
  logic [FIELD_W-1:0] inc_sec;

  assign is_zero  = (min_q == '0) && (sec_q == '0);
  assign last_sec = (min_q == '0) && (sec_q == FIELD_W'(1));
  assign inc_min  = (min_q >= MIN_TOP) ? '0 : min_q + 1'b1;
  assign inc_sec  = (sec_q >= SEC_MAX) ? '0 : sec_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= CH_IDLE;
      min_q     <= '0;
      sec_q     <= '0;
      pmin_q    <= '0;
      psec_q    <= '0;
      rep_q     <= 1'b0;
      bcnt_q    <= '0;
      running_q <= 1'b0;
      buzzer_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      pmin_q    <= pmin_d;
      psec_q    <= psec_d;
      rep_q     <= rep_d;
      bcnt_q    <= bcnt_d;
      running_q <= (state_d == CH_RUN);
      buzzer_q  <= (state_d == CH_RING);
    end
  end

  // Commands are evaluated in priority order; a command that does not apply
  // in the current state does not block a lower-priority one. Any command
  // that does act consumes the concurrent tick.
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    pmin_d  = pmin_q;
    psec_d  = psec_q;
    rep_d   = rep_q;
    bcnt_d  = bcnt_q;

    if (clr) begin
      state_d = CH_IDLE;
      min_d   = '0;
      sec_d   = '0;
      pmin_d  = '0;
      psec_d  = '0;
      rep_d   = 1'b0;
      bcnt_d  = '0;
    end else begin
      unique case (state_q)
        CH_IDLE: begin
          if (start && !is_zero) begin
            state_d = CH_RUN;
            rep_d   = repeat_en;
          end else if (add_min) begin
            // In IDLE the preset tracks the displayed value.
            min_d  = inc_min;
            pmin_d = inc_min;
            psec_d = sec_q;
          end else if (add_sec) begin
            sec_d  = inc_sec;
            psec_d = inc_sec;
            pmin_d = min_q;
          end
        end

        CH_RUN: begin
          if (pause) begin
            state_d = CH_PAUSE;
          end else if (sec_tick) begin
            if (is_zero || last_sec) begin
              // 00:00 can only be seen here if it was dialled in while
              // paused; treat it as already expired.
              state_d = CH_RING;
              min_d   = '0;
              sec_d   = '0;
              bcnt_d  = '0;
            end else if (sec_q != '0) begin
              sec_d = sec_q - 1'b1;
            end else begin
              min_d = min_q - 1'b1;
              sec_d = SEC_MAX;
            end
          end
        end

        CH_PAUSE: begin
          // Edits while paused change the live value only, not the preset.
          if (start) begin
            state_d = CH_RUN;
          end else if (add_min) begin
            min_d = inc_min;
          end else if (add_sec) begin
            sec_d = inc_sec;
          end
        end

        CH_RING: begin
          if (sec_tick) begin
            if (bcnt_q == BCNT_END) begin
              bcnt_d = '0;
              if (rep_q) begin
                state_d = CH_RUN;
                min_d   = pmin_q;
                sec_d   = psec_q;
              end else begin
                state_d = CH_IDLE;
                min_d   = '0;
                sec_d   = '0;
              end
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end
        end

        default: state_d = CH_IDLE;
      endcase
    end
  end

  assign min_left = min_q;
  assign sec_left = sec_q;
  assign running  = running_q;
  assign buzzer   = buzzer_q;

endmodule

// File: rtl/multi_timer_bank.sv
// Bank of NUM_CH countdown timers sharing one seconds prescaler and one button set.
// Latency: button edge or tick acts at the sampling edge; all outputs come from flops.
// Backpressure: none; buttons are edge-detected commands, held buttons act once.
//
// Ports:
//   clk, reset                      clock, async active-low reset
//   sel_ch                          channel addressed by the buttons (out of range = no-op)
//   add_minute/add_second           preset increment buttons
//   start_btn/pause_btn/clear_btn   channel control buttons
//   repeat_en                       auto-repeat, captured on start
//   timer_min_left/timer_sec_left   packed 6-bit fields, channel i at [6i+5:6i]
//   running/timer_buzzer            per-channel RUN / RING flags
//   any_buzzer                      OR of all buzzers
module multi_timer_bank
  import timer_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int TICK_DIV  = 1,
  parameter int MAX_MIN   = 59,
  parameter int BUZZ_SECS = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [idx_w(NUM_CH)-1:0]    sel_ch,
  input  logic                        add_minute,
  input  logic                        add_second,
  input  logic                        start_btn,
  input  logic                        pause_btn,
  input  logic                        clear_btn,
  input  logic                        repeat_en,
  output logic [FIELD_W*NUM_CH-1:0]   timer_min_left,
  output logic [FIELD_W*NUM_CH-1:0]   timer_sec_left,
  output logic [NUM_CH-1:0]           running,
  output logic [NUM_CH-1:0]           timer_buzzer,
  output logic                        any_buzzer
);

  localparam int SEL_W = idx_w(NUM_CH);
  localparam int PRE_W = idx_w(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(TICK_DIV - 1);

  // Button bit order: {clear, start, pause, add_minute, add_second}.
  localparam int B_AS = 0;
  localparam int B_AM = 1;
  localparam int B_PA = 2;
  localparam int B_ST = 3;
  localparam int B_CL = 4;

  logic [PRE_W-1:0] presc_q;
  logic             sec_tick;
  logic [4:0]       btn_now, btn_q, btn_rise;
  logic             sel_ok;

  // Free-running prescaler; nothing but reset ever realigns it.
  assign sec_tick = (presc_q == PRE_TOP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= sec_tick ? '0 : presc_q + 1'b1;
    end
  end

  assign btn_now = {clear_btn, start_btn, pause_btn, add_minute, add_second};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_q <= '0;
    end else begin
      btn_q <= btn_now;
    end
  end

  assign btn_rise = btn_now & ~btn_q;
  assign sel_ok   = (int'(sel_ch) < NUM_CH);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic       hit;
    logic [4:0] stb;

    assign hit = sel_ok && (sel_ch == SEL_W'(i));
    assign stb = btn_rise & {5{hit}};

    timer_channel #(
      .MAX_MIN   (MAX_MIN),
      .BUZZ_SECS (BUZZ_SECS)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .sec_tick  (sec_tick),
      .clr       (stb[B_CL]),
      .start     (stb[B_ST]),
      .pause     (stb[B_PA]),
      .add_min   (stb[B_AM]),
      .add_sec   (stb[B_AS]),
      .repeat_en (repeat_en),
      .min_left  (timer_min_left[FIELD_W*i +: FIELD_W]),
      .sec_left  (timer_sec_left[FIELD_W*i +: FIELD_W]),
      .running   (running[i]),
      .buzzer    (timer_buzzer[i])
    );
  end

  // OR of channel flops only, so still free of any input-to-output path.
  assign any_buzzer = |timer_buzzer;

endmodule

// File: tb/tb_multi_timer_bank.sv
// Bench for multi_timer_bank: directed scenarios plus random buttons vs a seconds-based model.
// Latency: n/a.
// Backpressure: n/a.
module tb_multi_timer_bank;

  localparam int NUM_CH    = 5;
  localparam int TICK_DIV  = 1;
  localparam int MAX_MIN   = 59;
  localparam int BUZZ_SECS = 10;
  localparam int SW        = 3;

  localparam int MS_IDLE = 0, MS_RUN = 1, MS_PAUSE = 2, MS_RING = 3;
  localparam int B_AS = 0, B_AM = 1, B_PA = 2, B_ST = 3, B_CL = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [SW-1:0]     sel_ch = '0;
  logic              add_minute = 1'b0, add_second = 1'b0;
  logic              start_btn = 1'b0, pause_btn = 1'b0, clear_btn = 1'b0;
  logic              repeat_en = 1'b0;
  logic [6*NUM_CH-1:0] timer_min_left, timer_sec_left;
  logic [NUM_CH-1:0] running, timer_buzzer;
  logic              any_buzzer;

  int n_chk  = 0;
  int n_fail = 0;

  multi_timer_bank #(
    .NUM_CH(NUM_CH), .TICK_DIV(TICK_DIV), .MAX_MIN(MAX_MIN), .BUZZ_SECS(BUZZ_SECS)
  ) u_dut (
    .clk            (clk),
    .reset          (reset),
    .sel_ch         (sel_ch),
    .add_minute     (add_minute),
    .add_second     (add_second),
    .start_btn      (start_btn),
    .pause_btn      (pause_btn),
    .clear_btn      (clear_btn),
    .repeat_en      (repeat_en),
    .timer_min_left (timer_min_left),
    .timer_sec_left (timer_sec_left),
    .running        (running),
    .timer_buzzer   (timer_buzzer),
    .any_buzzer     (any_buzzer)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: each channel's value is held as total seconds remaining,
  // the buzzer as seconds of ringing left.
  int m_st [NUM_CH];
  int m_val[NUM_CH];
  int m_pre[NUM_CH];
  int m_bl [NUM_CH];
  bit m_rep[NUM_CH];
  int m_presc;
  bit [4:0] m_prev;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_st[c] = MS_IDLE; m_val[c] = 0; m_pre[c] = 0; m_bl[c] = 0; m_rep[c] = 1'b0;
    end
    m_presc = 0;
    m_prev  = '0;
  endtask

  task automatic model_step();
    bit tick;
    bit [4:0] now, rise;
    tick    = (m_presc == TICK_DIV - 1);
    m_presc = tick ? 0 : m_presc + 1;
    now     = {clear_btn, start_btn, pause_btn, add_minute, add_second};
    rise    = now & ~m_prev;
    m_prev  = now;
    for (int c = 0; c < NUM_CH; c++) begin
      bit hit;
      int mm, ss;
      hit = (int'(sel_ch) == c);
      mm  = m_val[c] / 60;
      ss  = m_val[c] % 60;
      if (hit && rise[B_CL]) begin
        m_st[c] = MS_IDLE; m_val[c] = 0; m_pre[c] = 0; m_rep[c] = 1'b0;
      end else begin
        case (m_st[c])
          MS_IDLE: begin
            if (hit && rise[B_ST] && m_val[c] != 0) begin
              m_st[c] = MS_RUN; m_rep[c] = repeat_en;
            end else if (hit && rise[B_AM]) begin
              m_val[c] = ((mm == MAX_MIN) ? 0 : mm + 1) * 60 + ss; m_pre[c] = m_val[c];
            end else if (hit && rise[B_AS]) begin
              m_val[c] = mm * 60 + ((ss == 59) ? 0 : ss + 1); m_pre[c] = m_val[c];
            end
          end
          MS_RUN: begin
            if (hit && rise[B_PA]) begin
              m_st[c] = MS_PAUSE;
            end else if (tick) begin
              if (m_val[c] > 0) m_val[c]--;
              if (m_val[c] == 0) begin
                m_st[c] = MS_RING; m_bl[c] = BUZZ_SECS;
              end
            end
          end
          MS_PAUSE: begin
            if (hit && rise[B_ST]) m_st[c] = MS_RUN;
            else if (hit && rise[B_AM]) m_val[c] = ((mm == MAX_MIN) ? 0 : mm + 1) * 60 + ss;
            else if (hit && rise[B_AS]) m_val[c] = mm * 60 + ((ss == 59) ? 0 : ss + 1);
          end
          default: begin
            if (tick) begin
              m_bl[c]--;
              if (m_bl[c] == 0) begin
                if (m_rep[c]) begin
                  m_st[c] = MS_RUN; m_val[c] = m_pre[c];
                end else begin
                  m_st[c] = MS_IDLE; m_val[c] = 0;
                end
              end
            end
          end
        endcase
      end
    end
  endtask

  task automatic compare_all();
    logic [6*NUM_CH-1:0] em, es;
    logic [NUM_CH-1:0]   er, eb;
    for (int c = 0; c < NUM_CH; c++) begin
      em[6*c +: 6] = 6'(m_val[c] / 60);
      es[6*c +: 6] = 6'(m_val[c] % 60);
      er[c]        = (m_st[c] == MS_RUN);
      eb[c]        = (m_st[c] == MS_RING);
    end
    check("model_min", 32'(timer_min_left), 32'(em));
    check("model_sec", 32'(timer_sec_left), 32'(es));
    check("model_running", 32'(running), 32'(er));
    check("model_buzzer", 32'(timer_buzzer), 32'(eb));
    check("model_any_buzzer", 32'(any_buzzer), 32'(|eb));
  endtask

  // One clock: model and DUT advance on the same edge, compared 1 ns later.
  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
    compare_all();
    @(negedge clk);
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      B_AS:    add_second = v;
      B_AM:    add_minute = v;
      B_PA:    pause_btn  = v;
      B_ST:    start_btn  = v;
      default: clear_btn  = v;
    endcase
  endtask

  task automatic press(input int b, input int c);
    sel_ch = SW'(c);
    set_btn(b, 1'b1);
    cycle();
    set_btn(b, 1'b0);
    cycle();
  endtask

  function automatic int dmin(input int c);
    return int'(timer_min_left[6*c +: 6]);
  endfunction

  function automatic int dsec(input int c);
    return int'(timer_sec_left[6*c +: 6]);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_min"}, 32'(timer_min_left), 32'd0);
    check({tag, "_sec"}, 32'(timer_sec_left), 32'd0);
    check({tag, "_running"}, 32'(running), 32'd0);
    check({tag, "_buzzer"}, 32'(timer_buzzer), 32'd0);
    check({tag, "_any"}, 32'(any_buzzer), 32'd0);
  endtask

  initial begin
    // Power-on reset.
    #1 reset = 1'b0;
    #1;
    check_all_zero("reset");
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // ch0: 05:00 countdown to ring and back to idle.
    for (int i = 0; i < 5; i++) press(B_AM, 0);
    check("a_preset_min", dmin(0), 5);
    sel_ch = 0; start_btn = 1'b1;
    cycle();
    check("a_k_min", dmin(0), 5);
    check("a_k_sec", dsec(0), 0);
    check("a_k_running", running[0], 1);
    start_btn = 1'b0;
    cycle();
    check("a_k1_min", dmin(0), 4);
    check("a_k1_sec", dsec(0), 59);
    repeat (298) cycle();
    check("a_k299_sec", dsec(0), 1);
    check("a_k299_buzz", timer_buzzer[0], 0);
    cycle();
    check("a_k300_min", dmin(0), 0);
    check("a_k300_sec", dsec(0), 0);
    check("a_k300_buzz", timer_buzzer[0], 1);
    check("a_k300_any", any_buzzer, 1);
    repeat (9) cycle();
    check("a_k309_buzz", timer_buzzer[0], 1);
    cycle();
    check("a_k310_buzz", timer_buzzer[0], 0);
    check("a_k310_running", running[0], 0);

    // ch1: 00:03 with repeat.
    for (int i = 0; i < 3; i++) press(B_AS, 1);
    sel_ch = 1; repeat_en = 1'b1; start_btn = 1'b1;
    cycle();
    start_btn = 1'b0; repeat_en = 1'b0;
    repeat (2) cycle();
    check("b_k2_sec", dsec(1), 1);
    cycle();
    check("b_ring1", timer_buzzer[1], 1);
    repeat (9) cycle();
    check("b_ring1_hold", timer_buzzer[1], 1);
    cycle();
    check("b_reload_sec", dsec(1), 3);
    check("b_reload_run", running[1], 1);
    check("b_reload_buzz", timer_buzzer[1], 0);
    repeat (3) cycle();
    check("b_ring2", timer_buzzer[1], 1);
    sel_ch = 1; clear_btn = 1'b1;
    cycle();
    check("b_clear_buzz", timer_buzzer[1], 0);
    check("b_clear_sec", dsec(1), 0);
    clear_btn = 1'b0;
    cycle();

    // ch3 runs in the background while ch0 is paused and resumed.
    press(B_AM, 3);
    press(B_ST, 3);
    press(B_AM, 0);
    press(B_AM, 0);
    check("c_preset", dmin(0) * 60 + dsec(0), 120);
    sel_ch = 0; start_btn = 1'b1;
    cycle();
    start_btn = 1'b0;
    repeat (5) cycle();
    check("c_5ticks", dmin(0) * 60 + dsec(0), 115);
    pause_btn = 1'b1;
    cycle();
    pause_btn = 1'b0;
    check("c_paused_run", running[0], 0);
    repeat (20) cycle();
    check("c_hold_min", dmin(0), 1);
    check("c_hold_sec", dsec(0), 55);
    start_btn = 1'b1;
    cycle();
    start_btn = 1'b0;
    check("c_resume_sec", dsec(0), 55);
    cycle();
    check("c_resume_tick", dsec(0), 54);
    check("c_ch3_running", running[3], 1);
    press(B_CL, 0);

    // ch4 edge cases: wraps, start at zero, held start, clear+start.
    for (int i = 0; i < 59; i++) press(B_AM, 4);
    check("d_min59", dmin(4), 59);
    press(B_AM, 4);
    check("d_min_wrap", dmin(4), 0);
    for (int i = 0; i < 59; i++) press(B_AS, 4);
    check("d_sec59", dsec(4), 59);
    press(B_AS, 4);
    check("d_sec_wrap", dsec(4), 0);
    press(B_ST, 4);
    check("d_start_zero", running[4], 0);
    for (int i = 0; i < 30; i++) press(B_AS, 4);
    sel_ch = 4; start_btn = 1'b1;
    cycle(); cycle(); cycle();
    pause_btn = 1'b1;
    cycle();
    pause_btn = 1'b0;
    repeat (6) cycle();
    start_btn = 1'b0;
    check("d_held_running", running[4], 0);
    check("d_held_sec", dsec(4), 28);
    cycle();
    clear_btn = 1'b1; start_btn = 1'b1;
    cycle();
    clear_btn = 1'b0; start_btn = 1'b0;
    check("d_clr_start_run", running[4], 0);
    check("d_clr_start_sec", dsec(4), 0);
    cycle();

    // Out-of-range select is a no-op.
    for (int i = 0; i < 5; i++) press(B_AS, 4);
    press(B_ST, NUM_CH);
    press(B_AM, NUM_CH);
    check("e_bad_sel_run", running[4], 0);
    check("e_bad_sel_min", dmin(4), 0);
    check("e_bad_sel_sec", dsec(4), 5);

    // Async reset while ch2 is running.
    for (int i = 0; i < 5; i++) press(B_AS, 2);
    press(B_ST, 2);
    check("f_ch2_running", running[2], 1);
    #2 reset = 1'b0;
    #1;
    check_all_zero("f_async");
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // Random button traffic against the model.
    repeat (3000) begin
      if ($urandom_range(0, 3) == 0) sel_ch = SW'($urandom_range(0, NUM_CH));
      add_minute = ($urandom_range(0, 7) == 0);
      add_second = ($urandom_range(0, 3) == 0);
      start_btn  = ($urandom_range(0, 5) == 0);
      pause_btn  = ($urandom_range(0, 11) == 0);
      clear_btn  = ($urandom_range(0, 59) == 0);
      repeat_en  = 1'($urandom_range(0, 1));
      cycle();
    end
    add_minute = 1'b0; add_second = 1'b0; start_btn = 1'b0;
    pause_btn = 1'b0; clear_btn = 1'b0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_timer_bank.md
Name: multi_timer_bank

Overview:
- Parametrised successor to the single countdown timer inside the clock/mode FSM.
- Provides NUM_CH independent MM:SS countdown channels sharing one seconds prescaler.
- Each channel supports pause/resume, auto-repeat, and a bounded-length buzzer.
- Sits beside the clock core. The mode FSM routes the existing add_minute and set_timer buttons here, plus a channel select.

Parameters:
- NUM_CH, 4, number of timer channels (1..8).
- TICK_DIV, 1, clk cycles per one-second tick (1 = clk is 1 Hz).
- MAX_MIN, 59, highest settable minute value; minute increment wraps above this to 0.
- BUZZ_SECS, 10, seconds the buzzer stays high per expiry.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- sel_ch  in  $clog2(NUM_CH) (min 1)  channel targeted by all buttons.
- add_minute  in  1  button: +1 minute to the selected preset.
- add_second  in  1  button: +1 second to the selected preset.
- start_btn  in  1  button: start or resume the selected channel.
- pause_btn  in  1  button: pause the selected channel.
- clear_btn  in  1  button: abort the selected channel and zero it.
- repeat_en  in  1  latched into the selected channel on start.
- timer_min_left  out  6*NUM_CH  per-channel minutes remaining; channel i at [6i+5:6i].
- timer_sec_left  out  6*NUM_CH  per-channel seconds remaining.
- running  out  NUM_CH  channel in RUN.
- timer_buzzer  out  NUM_CH  channel in RING.
- any_buzzer  out  1  OR of timer_buzzer.

Behaviour:
- Reset (reset low, async): all channels IDLE; min/sec/preset 00:00; repeat=0; prescaler=0; all outputs 0.
- Buttons are rising-edge detected against a registered copy. An action takes effect at the first posedge where the button is sampled high after being low. A held button acts once.
- Tick: prescaler counts 0..TICK_DIV-1 and asserts sec_tick for one cycle when it equals TICK_DIV-1. The prescaler is free-running from reset and is never reset by buttons.
- Per-channel states: IDLE, RUN, PAUSE, RING.
- IDLE:
  - add_minute: min = (min==MAX_MIN) ? 0 : min+1. Preset mirrors the value.
  - add_second: sec = (sec==59) ? 0 : sec+1. Preset mirrors the value.
  - start with nonzero value: latch repeat_en, go to RUN.
  - start at 00:00: ignored.
- RUN:
  - On sec_tick: if sec>0, sec-1; else min-1 and sec=59.
  - A tick that reaches 00:00 moves the channel to RING at the same edge; the buzzer count starts at 0.
  - pause: go to PAUSE; value frozen.
  - add buttons: ignored.
- PAUSE: start goes to RUN; add buttons modify the value only (preset unchanged); ticks ignored.
- RING:
  - timer_buzzer=1. Each sec_tick increments the buzzer count.
  - When the count reaches BUZZ_SECS: if repeat, reload the preset and go to RUN; else go to IDLE at 00:00 with the preset retained.
  - start and pause: ignored.
- clear, in any state: go to IDLE; min, sec and preset = 0; repeat=0; buzzer drops at that edge.
- Same-cycle priority for the selected channel: clear > start > pause > add_minute > add_second.
- A button edge coincident with sec_tick: the button action wins, and that tick is not applied to the channel that cycle.
- Unselected channels are unaffected by buttons and keep counting.
- sel_ch >= NUM_CH: all buttons ignored.
- All outputs are registered; no combinational path from the inputs.

Decomposition:
- Package timer_pkg: channel state enum (IDLE/RUN/PAUSE/RING), the constant 59, the 6-bit field width, and the channel index width function.
- Sub-module timer_channel: one channel FSM with value, preset and buzzer counter.
- Top level: prescaler, edge detectors, sel_ch decode into per-channel strobes, generate loop of timer_channel, output packing and any_buzzer OR.

Test Plan:
- Reset low mid-RUN on channel 2 → all outputs 0 immediately (async), before the next clk edge.
- TICK_DIV=1, ch0: 5× add_minute, then start at edge k:
  - Value reads 05:00; 04:59 after edge k+1.
  - 00:00 and timer_buzzer[0]=1 at edge k+300.
  - Buzzer low and IDLE at edge k+310.
- ch1 set to 00:03, repeat_en=1, start:
  - RING after 3 ticks; reload to 00:03 and RUN after 10 more ticks.
  - Second RING 3 ticks later.
- ch0 running at 02:00; pause after 5 ticks → holds 01:55 for 20 cycles. start → resumes 01:54 on the next tick. ch3 started meanwhile counts unaffected.
- Edge cases:
  - add_minute at 59 → 00.
  - add_second at 59 → 00.
  - start at 00:00 → stays IDLE.
  - Held start_btn for 10 cycles → a single action.
  - clear during RING → buzzer 0 at the same edge.
- clear and start on the same edge → IDLE 00:00.
- sel_ch=NUM_CH with start → no channel changes.
